// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_t  - two-state handshake FSM encoding
//   mem_req_t    - one memory access (write enable, address, write data),
//                  used for both requesters and for the muxed DataMem port
//   STARVE_CNT_W - width of the debug starvation counter (STARVE_MAX <= 15)
package dmem_arb_pkg;

  localparam int ARB_ADDR_W   = 32;
  localparam int ARB_DATA_W   = 32;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_ACK  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: saturating up-counter with clear and hold.
// Counts consecutive cycles the debug requester has been passed over.
//   clk, rst_n - clock, asynchronous active-low reset
//   inc        - advance by one (ignored once the count reaches MAX)
//   clr        - return to zero; wins over inc
//   cnt        - current count
//   at_max     - count equals MAX, debug must be forced through
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic                    clr,
  output logic [STARVE_CNT_W-1:0] cnt,
  output logic                    at_max
);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == STARVE_CNT_W'(MAX));
  assign cnt    = cnt_q;

  // NOTE: the default assignment first keeps every path driven, so no latch
  // is inferred; with neither inc nor clr the counter simply holds.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + STARVE_CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values computed in always_comb, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single DataMem port between the single-cycle core
// and a debug/IO requester (switches, UART loader).
//   Core side : cpu_valid/cpu_we/cpu_addr/cpu_wdata in, cpu_rdata (straight
//               from mem_rdata) and cpu_stall out. A stalled core replays the
//               same access next cycle.
//   Debug side: dbg_req/dbg_we/dbg_addr/dbg_wdata in (held until ack),
//               dbg_ack one-cycle pulse, dbg_rdata registered read data.
//   Memory    : mem_we/mem_addr/mem_wdata out, mem_rdata in (combinational).
//   Perf      : perf_stall_cnt (stall cycles), perf_dbg_cnt (debug acks).
// Build option: define DMEM_ARB_PERF_EN to build the perf counters; otherwise
// the perf ports are tied to zero and no counter flops exist.
// Debug normally waits for a core idle cycle, but after STARVE_MAX consecutive
// losing cycles it is forced through and the core is stalled for one cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       perf_stall_cnt,
  output logic [15:0]       perf_dbg_cnt
);

  arb_state_t              state_q, state_d;
  logic [DATA_W-1:0]       dbg_rdata_q, dbg_rdata_d;
  logic                    is_idle;
  logic                    gnt_dbg;
  logic                    starve_inc, starve_clr, starve_at_max;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  mem_req_t                cpu_mreq, dbg_mreq, mem_mreq;

  assign is_idle = (state_q == ARB_IDLE);

  // Debug is only eligible in IDLE, so a request still high during its own
  // ack cycle cannot be granted twice.
  assign gnt_dbg   = is_idle & dbg_req & (~cpu_valid | starve_at_max);
  assign cpu_stall = gnt_dbg & cpu_valid;

  // Starvation tracking only moves in IDLE; ACK holds the count.
  assign starve_inc = is_idle & dbg_req & ~gnt_dbg;
  assign starve_clr = is_idle & (gnt_dbg | ~dbg_req);

  dmem_arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .cnt    (starve_cnt),
    .at_max (starve_at_max)
  );

  // A CPU that loses arbitration never drives mem_we; its store is replayed.
  assign cpu_mreq = '{we: cpu_valid & cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign dbg_mreq = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
  assign mem_mreq = gnt_dbg ? dbg_mreq : cpu_mreq;

  assign mem_we    = mem_mreq.we;
  assign mem_addr  = mem_mreq.addr;
  assign mem_wdata = mem_mreq.wdata;
  assign cpu_rdata = mem_rdata;

  always_comb begin
    state_d     = state_q;
    dbg_rdata_d = dbg_rdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_dbg) begin
          // Captured on writes too: the requester sees the pre-write word.
          dbg_rdata_d = mem_rdata;
          state_d     = ARB_ACK;
        end
      end
      ARB_ACK:  state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // NOTE: dbg_rdata is a single register (not a memory), so it is reset with
  // the FSM; a reset mid-handshake discards the pending ack and its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign dbg_ack   = (state_q == ARB_ACK);
  assign dbg_rdata = dbg_rdata_q;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_dbg_q, perf_dbg_d;

  // Both counters wrap naturally at their width.
  always_comb begin
    perf_stall_d = perf_stall_q + 32'(cpu_stall);
    perf_dbg_d   = perf_dbg_q + 16'(dbg_ack);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_dbg_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_dbg_q   <= perf_dbg_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_dbg_cnt   = perf_dbg_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_dbg_cnt   = '0;
`endif

endmodule
